renode_apb3_manager: RTL and testbench
======================================

Name: renode_apb3_manager

Overview:
- APB3 manager (requester) that turns simple valid/ready transaction requests into APB3 SETUP/ACCESS transfers.
- Returns read data and error status on a response channel.
- Sits between a Renode-side or on-chip transaction source and APB3 completers wired through the team's APB3 interface signal set.
- Includes a wait-state timeout so that a hung completer cannot stall the source.

Parameters:
- AddressWidth, 20, width of req_addr and paddr.
- DataWidth, 32, width of data buses. Legal values are 8, 16, 24 and 32; any other value raises an elaboration-time $error.
- TimeoutCycles, 256, maximum number of ACCESS cycles with pready low before the transfer is aborted. A value of 0 disables the timeout.

Ports:
- pclk  in  1  clock, all logic on the rising edge.
- presetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  manager can accept a request.
- req_addr  in  AddressWidth  transfer address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DataWidth  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  source accepts the response.
- rsp_rdata  out  DataWidth  read data; 0 for writes and for errors.
- rsp_error  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer aborted by the timeout.
- paddr  out  AddressWidth  APB address.
- pselx  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DataWidth  APB write data.
- pready  in  1  completer ready.
- prdata  in  DataWidth  completer read data.
- pslverr  in  1  completer error.

Behaviour:
- One clock (pclk). Reset is asynchronous and active-low (presetn).
- While presetn is low, every output is 0, including req_ready. State is forced to IDLE and the wait counter to 0.
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered; req_ready is 1 only in IDLE, from the first edge after reset release.
- IDLE:
  - On an edge with req_valid & req_ready, latch req_addr, req_write and req_wdata into paddr, pwrite and pwdata.
  - Set pselx=1 and penable=0, then move to SETUP.
- SETUP: lasts exactly one cycle, then moves to ACCESS with penable=1. pready and pslverr are ignored in SETUP.
- ACCESS, when pready=1:
  - Capture rsp_rdata: prdata for a read with pslverr=0, otherwise 0.
  - Set rsp_error=pslverr and rsp_timeout=0.
  - Drop pselx and penable, set rsp_valid=1, move to RESP.
- ACCESS, when pready=0:
  - Increment the wait counter.
  - If TimeoutCycles != 0 and the counter reaches TimeoutCycles, abort: drop pselx and penable, set rsp_valid=1, rsp_error=1, rsp_timeout=1 and rsp_rdata=0, then move to RESP.
  - The counter is $clog2(TimeoutCycles+1) bits wide, saturates and never wraps, and clears on entry to SETUP.
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - On an edge with rsp_ready=1, clear rsp_valid, rsp_error and rsp_timeout, then go to IDLE.
  - req_valid is ignored here; no new transfer starts.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS and keep their last values afterwards. pwdata is latched for reads as well.
- Latency with zero wait states: rsp_valid is high 3 cycles after the accept edge; each wait state adds 1 cycle.
- Minimum issue interval is 4 cycles when rsp_ready is held high.
- Reset asserted mid-transfer:
  - Immediate asynchronous abort; pselx and penable drop without waiting for a clock.
  - No response is produced for the aborted request.
- No address alignment checking and no byte strobes (APB3 only).

Test Plan:
- Zero-wait write: request addr=0x00010, wdata=0xDEADBEEF with pready tied 1 -> pselx=1/penable=0 at cycle 1, penable=1 at cycle 2, rsp_valid=1 at cycle 3 with rsp_error=0 and rsp_rdata=0; pwdata=0xDEADBEEF throughout.
- Read with 3 wait states: addr=0x00404, pready low for 3 ACCESS cycles, prdata=0x12345678 -> rsp_valid 6 cycles after accept, rsp_rdata=0x12345678; paddr=0x00404 stable for all ACCESS cycles.
- Slave error: write to 0x00008 with pslverr=1 and pready=1 -> rsp_error=1, rsp_timeout=0, rsp_rdata=0, pselx=0 in RESP.
- Timeout with TimeoutCycles=8 and pready stuck at 0: read -> exactly 8 ACCESS cycles, then pselx and penable drop, rsp_error=1, rsp_timeout=1, rsp_rdata=0; next request completes normally.
- Backpressure: rsp_ready held 0 for 5 cycles while req_valid=1 with a second request -> rsp_* stable, req_ready=0, pselx=0; second request accepted on the first edge after the RESP handshake.
- Reset during ACCESS (presetn low mid-cycle) -> all outputs 0 before the next edge and no rsp_valid; after release, a read of 0x00020 completes with 3-cycle latency.

Source files
------------

// File: rtl/renode_apb3_manager.sv
// APB3 manager: turns valid/ready requests into APB3 SETUP/ACCESS transfers.
// A wait-state timeout keeps a hung completer from stalling the source.
module renode_apb3_manager #(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic                    req_write,
    input  logic [DataWidth-1:0]    req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic [AddressWidth-1:0] paddr,
    output logic                    pselx,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DataWidth-1:0]    pwdata,
    input  logic                    pready,
    input  logic [DataWidth-1:0]    prdata,
    input  logic                    pslverr
);

    localparam bit TmoEn = (TimeoutCycles > 0);
    localparam int CntW  = TmoEn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        CntW'(TmoEn ? TimeoutCycles - 1 : 0);
    localparam logic [CntW-1:0] CntMax = '1;

    if (DataWidth != 8 && DataWidth != 16 &&
        DataWidth != 24 && DataWidth != 32) begin : g_bad_width
        $error("renode_apb3_manager: illegal DataWidth %0d", DataWidth);
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    req_ready_d;
    logic                    rsp_valid_d;
    logic [DataWidth-1:0]    rsp_rdata_d;
    logic                    rsp_error_d;
    logic                    rsp_timeout_d;
    logic [AddressWidth-1:0] paddr_d;
    logic                    pselx_d;
    logic                    penable_d;
    logic                    pwrite_d;
    logic [DataWidth-1:0]    pwdata_d;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            paddr       <= '0;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_error   <= rsp_error_d;
            rsp_timeout <= rsp_timeout_d;
            paddr       <= paddr_d;
            pselx       <= pselx_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            pwdata      <= pwdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_error_d   = rsp_error;
        rsp_timeout_d = rsp_timeout;
        paddr_d       = paddr;
        pselx_d       = pselx;
        penable_d     = penable;
        pwrite_d      = pwrite;
        pwdata_d      = pwdata;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    paddr_d   = req_addr;
                    pwrite_d  = req_write;
                    pwdata_d  = req_wdata;
                    pselx_d   = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d   = (!pwrite && !pslverr) ? prdata : '0;
                    rsp_error_d   = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    pselx_d       = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    // this cycle is wait number TimeoutCycles: give up
                    if (TmoEn && cnt_q == CntLast) begin
                        rsp_rdata_d   = '0;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        pselx_d       = 1'b0;
                        penable_d     = 1'b0;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_error_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_renode_apb3_manager.sv
// Scoreboard bench for renode_apb3_manager: directed transfers against a
// scripted APB3 completer, responses checked by a decoupled monitor.
module tb_renode_apb3_manager;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [19:0] paddr;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    renode_apb3_manager #(
        .AddressWidth (20),
        .DataWidth    (32),
        .TimeoutCycles(8)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;

    int          cfg_waits = 0;
    bit          cfg_stuck = 0;
    bit          cfg_err = 0;
    logic [31:0] cfg_rd = '0;
    int          acc_total = 0;

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    always @(posedge pclk) cyc++;

    // scripted completer: pready only after cfg_waits ACCESS cycles
    always @(negedge pclk) begin
        prdata = cfg_rd;
        if (!presetn) begin
            acc_total = 0;
            pready    = 1'b0;
            pslverr   = 1'b0;
        end else if (pselx && penable) begin
            pready  = !cfg_stuck && (acc_total == cfg_waits);
            pslverr = cfg_err && pready;
            acc_total++;
        end else begin
            if (pselx) acc_total = 0;
            pready  = 1'b1;
            pslverr = cfg_err;
        end
    end

    int          c0 = 0;
    logic [19:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic        exp_wr = 1'b0;
    logic        prev_rv = 1'b0;
    logic        prev_pen = 1'b0;

    always @(negedge pclk) begin
        if (!presetn) begin
            prev_rv  = 1'b0;
            prev_pen = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                c0        = cyc;
                exp_addr  = req_addr;
                exp_wdata = req_wdata;
                exp_wr    = req_write;
            end
            if (pselx && !penable)
                check("setup_cycle", 64'(cyc), 64'(c0 + 1));
            if (pselx && penable && !prev_pen)
                check("access_cycle", 64'(cyc), 64'(c0 + 2));
            if (pselx) begin
                check("paddr", 64'(paddr), 64'(exp_addr));
                check("pwdata", 64'(pwdata), 64'(exp_wdata));
                check("pwrite", 64'(pwrite), 64'(exp_wr));
            end
            if (rsp_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_rsp: rsp_valid with empty queue (cycle %0d)", cyc);
                end else begin
                    check("latency", 64'(cyc - c0), 64'(sb[0].lat));
                    check("access_count", 64'(acc_total),
                          64'(sb[0].lat - 2));
                    check("apb_idle_in_resp", {pselx, penable}, 0);
                end
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_error", 64'(rsp_error), 64'(e.err));
                check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            end
            prev_rv  = rsp_valid;
            prev_pen = penable;
        end
    end

    task automatic push(input logic [31:0] rd, input logic err,
                        input logic tmo, input int lat);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        e.tmo   = tmo;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [19:0] a, input logic w,
                         input logic [31:0] d);
        @(posedge pclk);
        #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
    endtask

    task automatic wait_accept(output int acc_cyc);
        int i;
        acc_cyc = -1;
        for (i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (req_ready) break;
        end
        if (i == 50) begin
            n_cmp++;
            n_mis++;
            $display("FAIL accept_timeout: req_ready never rose (cycle %0d)", cyc);
        end
        acc_cyc = cyc;
        @(posedge pclk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (sb.size() == 0 && !rsp_valid) break;
        end
        if (i == 100) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
        end
    endtask

    task automatic xfer(input logic [19:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int waits, input bit stuck, input bit err,
                        input logic [31:0] x_rd, input logic x_err,
                        input logic x_tmo, input int x_lat);
        int ac;
        cfg_rd    = rd;
        cfg_waits = waits;
        cfg_stuck = stuck;
        cfg_err   = err;
        push(x_rd, x_err, x_tmo, x_lat);
        drive(a, w, d);
        wait_accept(ac);
        drain();
    endtask

    initial begin
        int ac;
        int hs;
        int i;
        #12;
        check("reset_ctrl", {req_ready, rsp_valid, rsp_error,
              rsp_timeout, pselx, penable, pwrite}, 0);
        check("reset_data", {rsp_rdata, pwdata}, 0);
        check("reset_paddr", 64'(paddr), 0);
        #10;
        presetn = 1'b1;
        @(negedge pclk);
        check("ready_after_reset", 64'(req_ready), 1);

        // zero-wait write, slave error write, 3-wait read
        xfer(20'h00010, 1'b1, 32'hDEADBEEF, 32'hFFFF0000, 0, 0, 0,
             32'h0, 1'b0, 1'b0, 3);
        xfer(20'h00404, 1'b0, 32'h0000AAAA, 32'h12345678, 3, 0, 0,
             32'h12345678, 1'b0, 1'b0, 6);
        xfer(20'h00008, 1'b1, 32'h01020304, 32'h77777777, 0, 0, 1,
             32'h0, 1'b1, 1'b0, 3);
        xfer(20'h0000C, 1'b0, 32'h0, 32'h89ABCDEF, 0, 0, 1,
             32'h0, 1'b1, 1'b0, 3);

        // timeout after 8 ACCESS cycles, then a normal read
        xfer(20'h00100, 1'b0, 32'h0, 32'hA5A5A5A5, 0, 1, 0,
             32'h0, 1'b1, 1'b1, 10);
        xfer(20'h00030, 1'b0, 32'h0, 32'hCAFEF00D, 1, 0, 0,
             32'hCAFEF00D, 1'b0, 1'b0, 4);

        // response backpressure with a second request waiting
        rsp_ready = 1'b0;
        cfg_rd    = 32'h11112222;
        cfg_waits = 0;
        cfg_stuck = 0;
        cfg_err   = 0;
        push(32'h11112222, 1'b0, 1'b0, 3);
        push(32'h0, 1'b0, 1'b0, 3);
        drive(20'h00044, 1'b0, 32'h0);
        wait_accept(ac);
        req_valid = 1'b1;
        req_addr  = 20'h00048;
        req_write = 1'b1;
        req_wdata = 32'h55667788;
        for (i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (rsp_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge pclk);
            check("bp_rsp_valid", 64'(rsp_valid), 1);
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'h11112222);
            check("bp_req_ready", 64'(req_ready), 0);
            check("bp_pselx", 64'(pselx), 0);
        end
        @(posedge pclk);
        #1;
        rsp_ready = 1'b1;
        hs = cyc;
        wait_accept(ac);
        check("bp_second_accept", 64'(ac), 64'(hs + 1));
        drain();

        // reset in the middle of ACCESS: no response may appear
        cfg_stuck = 1;
        drive(20'h00050, 1'b0, 32'h0);
        wait_accept(ac);
        for (i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (penable) break;
        end
        #2;
        presetn = 1'b0;
        #1;
        check("midreset_ctrl", {req_ready, rsp_valid, rsp_error,
              rsp_timeout, pselx, penable, pwrite}, 0);
        check("midreset_data", {rsp_rdata, pwdata}, 0);
        cfg_stuck = 0;
        repeat (2) @(negedge pclk);
        #2;
        presetn = 1'b1;
        xfer(20'h00020, 1'b0, 32'h0, 32'h0BADCAFE, 0, 0, 0,
             32'h0BADCAFE, 1'b0, 1'b0, 3);

        repeat (3) @(negedge pclk);
        check("queue_empty", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
